// File: rtl/rns_conv_sched.sv
// rns_conv_sched: round-robin front end sharing one combinational RNS
// reverse converter (`top`) between two requesters.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (bit i = requester i)
//   r1_*, r0_*, rm1_* residues mod 2^n+1, 2^n, 2^n-1 for requester 0/1
//   tag_*             requester tag carried through to the result
//   out_valid/ready   result handshake
//   out_n             converted signed integer (3n-bit two's complement)
//   out_src, out_tag  originating requester and its tag
//   out_err           residue range error (out_n forced to 0)
//   busy              FSM not IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no work; grant is offered to requesters
// CALC  | operand register drives the converter; result captured at end
// DONE  | result presented; on out_ready a new request may be accepted

// top: combinational reverse converter {2^n+1, 2^n, 2^n-1} -> signed 3n-bit.
// X = r0 + 2^n*Y, with Y recovered from its residues mod 2^n-1 and 2^n+1,
// then mapped to the symmetric signed range around 0.
module top #(
    parameter int n = 3
) (
    input  logic [n:0]     r1,
    input  logic [n-1:0]   r0,
    input  logic [n-1:0]   rm1,
    output logic [3*n-1:0] N
);
    localparam int W = 3 * n;
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] P0   = ONE << n;
    localparam logic [W-1:0] MP1  = P0 + ONE;
    localparam logic [W-1:0] MM1  = P0 - ONE;
    // 2^3n wraps to 0 in W bits, so this is 2^3n - 2^n
    localparam logic [W-1:0] MM   = (P0 << (2 * n)) - P0;
    localparam logic [W-1:0] HALF = MM >> 1;
    // inverse of (2^n+1) mod (2^n-1) is 2^(n-1)
    localparam logic [W-1:0] HH   = ONE << (n - 1);

    logic [W-1:0] r1_w, r0_w, rm1_w;
    logic [W-1:0] a, b, t, y, x;

    always_comb begin
        r1_w  = W'(r1);
        r0_w  = W'(r0);
        rm1_w = W'(rm1);
        // Y mod (2^n-1): 2^n == 1, so Y == rm1 - r0
        a = ((rm1_w % MM1) + MM1 - (r0_w % MM1)) % MM1;
        // Y mod (2^n+1): 2^n == -1, so Y == r0 - r1
        b = ((r0_w % MP1) + MP1 - (r1_w % MP1)) % MP1;
        t = (((a + MM1 - (b % MM1)) % MM1) * HH) % MM1;
        y = b + MP1 * t;
        x = r0_w + P0 * y;
        N = (x >= HALF) ? (x - MM) : x;
    end
endmodule

module rns_conv_sched #(
    parameter int N_BITS = 3,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [N_BITS:0]       r1_0,
    input  logic [N_BITS:0]       r1_1,
    input  logic [N_BITS-1:0]     r0_0,
    input  logic [N_BITS-1:0]     r0_1,
    input  logic [N_BITS-1:0]     rm1_0,
    input  logic [N_BITS-1:0]     rm1_1,
    input  logic [TAG_W-1:0]      tag_0,
    input  logic [TAG_W-1:0]      tag_1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*N_BITS-1:0]   out_n,
    output logic                  out_src,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_err,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [N_BITS:0]   R1_MAX  = {1'b1, {N_BITS{1'b0}}};
    localparam logic [N_BITS-1:0] RM1_BAD = {N_BITS{1'b1}};

    state_t                state_q, state_d;
    logic                  last_grant_q;
    logic [N_BITS:0]       op_r1_q;
    logic [N_BITS-1:0]     op_r0_q;
    logic [N_BITS-1:0]     op_rm1_q;
    logic [TAG_W-1:0]      op_tag_q;
    logic                  op_src_q;
    logic [3*N_BITS-1:0]   res_n_q;
    logic                  res_src_q;
    logic [TAG_W-1:0]      res_tag_q;
    logic                  res_err_q;

    logic [1:0]            grant;
    logic                  accept;
    logic                  sel;
    logic [3*N_BITS-1:0]   core_n;
    logic                  core_err;

    top #(.n(N_BITS)) u_core (
        .r1  (op_r1_q),
        .r0  (op_r0_q),
        .rm1 (op_rm1_q),
        .N   (core_n)
    );

    assign core_err = (op_r1_q > R1_MAX) | (op_rm1_q == RM1_BAD);

    // Sole valid requester wins; on a tie the one not served last wins.
    assign grant[0] = req_valid[0] & (~req_valid[1] | last_grant_q);
    assign grant[1] = req_valid[1] & (~req_valid[0] | ~last_grant_q);

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (|grant) state_d = CALC;
            end
            CALC: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    req_ready = grant;
                    state_d   = (|grant) ? CALC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = |(req_valid & req_ready);
    assign sel    = req_ready[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_r1_q      <= '0;
            op_r0_q      <= '0;
            op_rm1_q     <= '0;
            op_tag_q     <= '0;
            op_src_q     <= 1'b0;
            res_n_q      <= '0;
            res_src_q    <= 1'b0;
            res_tag_q    <= '0;
            res_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_r1_q      <= sel ? r1_1  : r1_0;
                op_r0_q      <= sel ? r0_1  : r0_0;
                op_rm1_q     <= sel ? rm1_1 : rm1_0;
                op_tag_q     <= sel ? tag_1 : tag_0;
                op_src_q     <= sel;
                last_grant_q <= sel;
            end
            if (state_q == CALC) begin
                res_n_q   <= core_err ? '0 : core_n;
                res_src_q <= op_src_q;
                res_tag_q <= op_tag_q;
                res_err_q <= core_err;
            end
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_n     = res_n_q;
    assign out_src   = res_src_q;
    assign out_tag   = res_tag_q;
    assign out_err   = res_err_q;
endmodule

// File: tb/tb_rns_conv_sched.sv
module tb_rns_conv_sched;
    localparam int NB = 3;
    localparam int TW = 4;
    localparam int W  = 3 * NB;
    localparam int MP = (1 << NB) + 1;
    localparam int M0 = (1 << NB);
    localparam int MM = (1 << NB) - 1;
    localparam int MT = MP * M0 * MM;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] req_valid, req_ready;
    logic [NB:0]   d_r1  [2];
    logic [NB-1:0] d_r0  [2];
    logic [NB-1:0] d_rm1 [2];
    logic [TW-1:0] d_tag [2];
    logic out_valid, out_ready, out_src, out_err, busy;
    logic [W-1:0]  out_n;
    logic [TW-1:0] out_tag;

    rns_conv_sched #(.N_BITS(NB), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .r1_0(d_r1[0]), .r1_1(d_r1[1]),
        .r0_0(d_r0[0]), .r0_1(d_r0[1]),
        .rm1_0(d_rm1[0]), .rm1_1(d_rm1[1]),
        .tag_0(d_tag[0]), .tag_1(d_tag[1]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_n(out_n), .out_src(out_src), .out_tag(out_tag),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  n;
        logic          src;
        logic [TW-1:0] tag;
        logic          err;
        int            acc;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_g = 1;
    int last_acc = 0;
    bit have_acc = 0;
    logic [1:0] last_hs;
    int hs_cyc;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: search the whole residue ring for the value with these residues.
    function automatic void ref_conv(input int r1, input int r0, input int rm1,
                                     output logic [W-1:0] n, output logic err);
        int x;
        x   = 0;
        err = (r1 > M0) || (rm1 == MM);
        n   = '0;
        if (!err) begin
            for (int v = 0; v < MT; v++)
                if ((v % MP) == r1 && (v % M0) == r0 && (v % MM) == rm1) x = v;
            n = (x >= MT / 2) ? W'(x - MT) : W'(x);
        end
    endfunction

    task automatic drive(input int i, input int r1, input int r0, input int rm1, input int tag);
        d_r1[i]  = (NB+1)'(r1);
        d_r0[i]  = NB'(r0);
        d_rm1[i] = NB'(rm1);
        d_tag[i] = TW'(tag);
        req_valid[i] = 1'b1;
    endtask

    task automatic drive_rand(input int i);
        int v;
        if ($urandom_range(0, 4) == 0)
            drive(i, $urandom_range(0, 2*M0 - 1), $urandom_range(0, M0 - 1),
                  $urandom_range(0, M0 - 1), $urandom_range(0, 15));
        else begin
            v = $urandom_range(0, MT - 1);
            drive(i, v % MP, v % M0, v % MM, $urandom_range(0, 15));
        end
    endtask

    // One clock: check request-side rules, record handshakes, retire accepted requests.
    task automatic tick();
        logic [1:0] hs;
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
            chk("ready_subset_of_valid", 32'((req_ready & ~req_valid) == 2'b00), 1);
            if (out_valid && !out_ready) chk("ready_zero_in_stall", 32'(req_ready), 0);
            if (req_valid == 2'b11 && req_ready != 2'b00)
                chk("round_robin_tie", 32'(req_ready), (last_g == 1) ? 1 : 2);
        end
        hs = rst ? 2'b00 : (req_valid & req_ready);
        if (hs != 2'b00) begin
            if (have_acc) chk("accept_spacing", 32'((cyc - last_acc) >= 2), 1);
            have_acc = 1;
            last_acc = cyc;
            hs_cyc   = cyc;
        end
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) begin
                ref_conv(int'(d_r1[i]), int'(d_r0[i]), int'(d_rm1[i]), e.n, e.err);
                e.src = (i == 1);
                e.tag = d_tag[i];
                e.acc = cyc;
                sbq.push_back(e);
                last_g = i;
            end
        end
        last_hs = hs;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        bit presenting = 0;
        bit stall = 0;
        int first_seen = 0;
        logic [W-1:0] p_n;
        logic p_src, p_err;
        logic [TW-1:0] p_tag;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                presenting = 0;
                stall = 0;
            end else begin
                if (stall) begin
                    chk("stall_valid_held", 32'(out_valid), 1);
                    chk("stall_n_held", 32'(out_n), 32'(p_n));
                    chk("stall_tag_held", 32'(out_tag), 32'(p_tag));
                    chk("stall_src_held", 32'(out_src), 32'(p_src));
                    chk("stall_err_held", 32'(out_err), 32'(p_err));
                end
                if (out_valid && !presenting) begin
                    presenting = 1;
                    first_seen = cyc;
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got n=0x%0h src=%0d tag=0x%0h required no output",
                                 out_n, out_src, out_tag);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_out_n", 32'(out_n), 32'(e.n));
                        chk("sb_out_src", 32'(out_src), 32'(e.src));
                        chk("sb_out_tag", 32'(out_tag), 32'(e.tag));
                        chk("sb_out_err", 32'(out_err), 32'(e.err));
                        chk("sb_latency", 32'(first_seen - e.acc), 2);
                    end
                    presenting = 0;
                end
                stall = out_valid && !out_ready;
                p_n = out_n; p_tag = out_tag; p_src = out_src; p_err = out_err;
            end
        end
    end

    task automatic one_shot(input string nm, input int i, input int r1, input int r0,
                            input int rm1, input int tag, input int en, input int ee);
        drive(i, r1, r0, rm1, tag);
        tick();
        chk({nm, "_accept"}, 32'(last_hs), (i == 1) ? 2 : 1);
        chk({nm, "_calc_busy"}, 32'(busy), 1);
        chk({nm, "_calc_novalid"}, 32'(out_valid), 0);
        tick();
        chk({nm, "_valid"}, 32'(out_valid), 1);
        chk({nm, "_n"}, 32'(out_n), 32'(en));
        chk({nm, "_src"}, 32'(out_src), 32'(i));
        chk({nm, "_tag"}, 32'(out_tag), 32'(tag));
        chk({nm, "_err"}, 32'(out_err), 32'(ee));
        chk({nm, "_done_busy"}, 32'(busy), 1);
        tick();
        chk({nm, "_idle_busy"}, 32'(busy), 0);
        chk({nm, "_idle_valid"}, 32'(out_valid), 0);
    endtask

    task automatic drain();
        req_valid = 2'b00;
        out_ready = 1'b1;
        for (int k = 0; k < 12 && (sbq.size() != 0 || busy); k++) tick();
        chk("drain_empty", 32'(sbq.size()), 0);
    endtask

    task automatic apply_reset_now();
        rst = 1'b1;
        sbq.delete();
        last_g = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic post_reset_checks(input string nm);
        chk({nm, "_valid"}, 32'(out_valid), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_n"}, 32'(out_n), 0);
        chk({nm, "_tag"}, 32'(out_tag), 0);
        chk({nm, "_src"}, 32'(out_src), 0);
        chk({nm, "_err"}, 32'(out_err), 0);
        rst = 1'b0;
        repeat (4) tick();
        chk({nm, "_no_stale"}, 32'(out_valid), 0);
        drive_rand(0);
        drive_rand(1);
        tick();
        chk({nm, "_first_tie_to_0"}, 32'(last_hs), 1);
        drain();
    endtask

    initial begin
        int srcs[6];
        int cycs[6];
        int cnt;
        int first;
        int rem[2];
        bit served;
        rst = 1'b1;
        req_valid = 2'b00;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d_r1[i] = '0; d_r0[i] = '0; d_rm1[i] = '0; d_tag[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_n", 32'(out_n), 0);
        chk("rst_src", 32'(out_src), 0);
        chk("rst_tag", 32'(out_tag), 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        one_shot("single0", 0, 5, 5, 5, 'hA, 5, 0);
        one_shot("neg1", 1, 8, 7, 6, 3, 'h1FF, 0);

        // Both requesters saturating, consumer always ready.
        cnt = 0;
        drive(0, 1, 1, 1, 0);
        drive(1, 2, 2, 2, 1);
        for (int k = 0; k < 40 && cnt < 6; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (last_hs[i]) begin
                    srcs[cnt] = i;
                    cycs[cnt] = hs_cyc;
                    cnt++;
                    drive(i, (cnt * 3 + i) % MP, (cnt * 3 + i) % M0, (cnt * 3 + i) % MM, cnt);
                end
            end
        end
        chk("b2b_count", 32'(cnt), 6);
        for (int j = 0; j < 6; j++) begin
            chk("b2b_src_seq", 32'(srcs[j]), 32'(j % 2));
            if (j > 0) chk("b2b_accept_every_2", 32'(cycs[j] - cycs[j-1]), 2);
        end
        drain();

        // Backpressure with both requesters pending.
        out_ready = 1'b0;
        drive_rand(0);
        drive_rand(1);
        tick();
        first = last_hs[1] ? 1 : 0;
        chk("bp_single_accept", 32'($onehot(last_hs)), 1);
        drive_rand(first);
        repeat (6) tick();
        chk("bp_held_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        chk("bp_next_grant_opposite", 32'(last_hs), (first == 0) ? 2 : 1);
        served = 0;
        for (int k = 0; k < 8 && !served; k++) begin
            tick();
            if (last_hs[first]) served = 1;
        end
        chk("bp_pending_served", 32'(served), 1);
        drain();

        one_shot("err_r1", 0, 9, 1, 1, 5, 0, 1);
        one_shot("err_rm1", 1, 2, 3, 7, 'hC, 0, 1);

        // Reset while in CALC.
        drive(0, 4, 4, 4, 7);
        tick();
        chk("rcalc_in_calc", 32'(busy), 1);
        apply_reset_now();
        post_reset_checks("rcalc");

        // Reset while in DONE under backpressure.
        out_ready = 1'b0;
        drive(1, 3, 3, 3, 9);
        tick();
        tick();
        chk("rdone_in_done", 32'(out_valid), 1);
        apply_reset_now();
        out_ready = 1'b1;
        post_reset_checks("rdone");

        // Randomized traffic with random consumer stalls.
        rem[0] = 80;
        rem[1] = 80;
        for (int k = 0; k < 4000 && (rem[0] > 0 || rem[1] > 0 || req_valid != 2'b00); k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && rem[i] > 0 && $urandom_range(0, 2) != 0) begin
                    drive_rand(i);
                    rem[i]--;
                end
            end
            tick();
        end
        chk("rand_all_issued", 32'(rem[0] + rem[1]), 0);
        chk("rand_all_accepted", 32'(req_valid), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rns_conv_sched.md
Name: rns_conv_sched

Overview:
- Sequential front end that shares one instance of the combinational signed reverse converter `top` between two requesters.
- `top` maps residues {2^n+1, 2^n, 2^n-1} to a 3n-bit signed integer.
- The block arbitrates between the requesters round-robin, registers operands and results around the core, range-checks the residues, and returns results with a valid/ready handshake tagged by source.
- It sits between the residue-arithmetic channels and the binary-domain consumer.

Parameters:
- N_BITS, 3, the moduli parameter n; passed to `top` as n.
- TAG_W, 4, width of the requester transaction tag carried through with each result.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; one-hot or zero.
- r1_0, r1_1  input  N_BITS+1  residue mod 2^n+1, requester 0 and 1.
- r0_0, r0_1  input  N_BITS  residue mod 2^n, requester 0 and 1.
- rm1_0, rm1_1  input  N_BITS  residue mod 2^n-1, requester 0 and 1.
- tag_0, tag_1  input  TAG_W  requester tag, requester 0 and 1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accept.
- out_n  output  3*N_BITS  converted signed integer, two's complement.
- out_src  output  1  index of the requester that issued this result.
- out_tag  output  TAG_W  tag of the request that produced this result.
- out_err  output  1  residue range error for this result.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything.
  - State goes to IDLE.
  - out_valid, out_n, out_src, out_tag, out_err and busy all go to 0.
  - last_grant goes to 1, so requester 0 wins the first tie.
  - Any in-flight operand or result is discarded; no output appears for it.
- FSM states: IDLE, CALC, DONE.
- IDLE: req_ready = grant vector.
  - Grant goes to the single valid requester.
  - If both requesters are valid, grant goes to the index != last_grant.
  - A handshake (req_valid[i] & req_ready[i]) latches r1, r0, rm1, tag and src into the operand register, updates last_grant=i, and moves to CALC.
  - With no request, stay in IDLE.
- CALC: the operand register drives `top`.
  - At the end of the cycle, capture N, src, tag and err into the result register, then go to DONE.
  - req_ready = 0.
- DONE: out_valid = 1; result outputs are held stable until out_ready.
  - If out_ready=0: stay in DONE, req_ready = 0, outputs unchanged.
  - If out_ready=1 with no request pending: go to IDLE; out_valid drops next cycle.
  - If out_ready=1 with a request pending: req_ready = grant in the same cycle, using the same round-robin rule. The accepted request goes straight to CALC (back-to-back mode).
- Latency: accept at cycle k gives out_valid at cycle k+2. Best-case throughput is one result every 2 cycles.
- req_ready is combinational from req_valid, state, last_grant and out_ready. It never depends on the r*/tag inputs.
- out_err = (r1 > 2^n) | (rm1 == 2^n-1).
  - rm1 == 2^n-1 is the non-canonical encoding of 0 and is rejected.
  - When out_err=1, out_n is forced to 0. src and tag are still valid.
- out_n equals `top`'s N for the latched residues, bit for bit. No extra sign handling is applied.
- A request that is valid but not granted must stay pending and must not be dropped. The round-robin rule guarantees each requester waits at most one result when the other is saturating.
- out_* are registered. No combinational path exists from req inputs to out_*.

Test Plan:
- Reset then single request from requester 0 (N_BITS=3): r1=5, r0=5, rm1=5, tag=4'hA.
  - Response: out_valid at k+2 with out_n=9'd5, out_src=0, out_tag=4'hA, out_err=0, busy high for 2 cycles.
- Negative value on requester 1: r1=8, r0=7, rm1=6, tag=3 (value -1).
  - Response: out_n=9'h1FF, out_src=1, out_err=0.
- Both requesters valid continuously, out_ready=1, 6 results.
  - Response: out_src sequence 0,1,0,1,0,1; a new accept every 2 cycles.
- Backpressure: out_ready held low for 5 cycles in DONE while req_valid=2'b11.
  - Response: out_n/out_tag stable, req_ready=0 throughout, no request lost.
  - After out_ready is released, the next grant goes to the opposite requester.
- Range errors: r1=9 (>8), then separately rm1=7.
  - Response: out_err=1, out_n=0, tag and src correct.
- Reset asserted in CALC, and separately in DONE with out_ready=0.
  - Response: next cycle out_valid=0, busy=0, no stale result after release.
  - The first grant after reset goes to requester 0 on a tie.
